// File: rtl/multdiv_unit.sv
// ---------------------------------------------------------------------------
// multdiv_unit
//   Multi-cycle signed multiply / divide unit. This is the sequential partner
//   of the single-cycle execute-stage ALU.
//
//   A one-cycle start pulse on ctrl_MULT or ctrl_DIV captures both operands.
//   The unit then runs WIDTH iterations, one per clock edge. After that it
//   raises data_resultRDY for exactly one cycle, together with data_result
//   and data_exception.
//
// Ports
//   clock           rising-edge clock
//   reset           asynchronous, active-low reset
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start multiply (has priority when both starts are high)
//   ctrl_DIV        start divide
//   data_result     low WIDTH bits of the product, or the quotient
//   data_exception  signed overflow or divide-by-zero; valid with the strobe
//   data_resultRDY  one-cycle completion strobe (high in the DONE state)
//   busy            high while an operation is iterating
//
// Handshake
//   A start pulse is accepted in every state; it aborts any operation that is
//   in flight, and the aborted operation never strobes. The consumer stalls
//   while busy is high and takes the result in the cycle where
//   data_resultRDY is high. data_result and data_exception keep their values
//   until the next completion or reset.
//
//   The FSM state is visible hierarchically as 'state' (type state_t) so that
//   checkers can bind to it.
// ---------------------------------------------------------------------------
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, stateNext;

    logic [5:0]       counter;
    // accHi/accLo form a shared shift register.
    //   Multiply: {partial product high, multiplier shifting out low}.
    //   Divide:   {partial remainder, dividend shifting into quotient}.
    logic [WIDTH:0]   accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] opMag;       // multiplicand or divisor magnitude
    logic             negResult;   // result sign = signA ^ signB
    logic             divByZero;
    logic             divOverflow; // most-negative / -1

    logic             start;
    logic             lastIter;

    // Operand magnitudes taken at the start edge.
    logic [WIDTH-1:0] magA, magB;

    // One-iteration datapath.
    logic [WIDTH:0]   sumHi;
    logic [WIDTH:0]   multHi;
    logic [WIDTH-1:0] multLo;
    logic [WIDTH:0]   shiftRem;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   divHi;
    logic [WIDTH-1:0] divLo;

    // Final-result shaping.
    logic [2*WIDTH-1:0] productMag;
    logic [2*WIDTH-1:0] productSigned;
    logic [WIDTH-1:0]   quotient;
    logic               multOverflow;

    assign start    = ctrl_MULT | ctrl_DIV;
    assign lastIter = (counter == 6'(WIDTH - 1));

    assign magA = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign magB = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    always_comb begin
        // Multiply step: add the multiplicand when the current multiplier bit
        // is set, then shift the whole {hi, lo} pair right by one.
        sumHi  = accHi + (accLo[0] ? {1'b0, opMag} : '0);
        multHi = {1'b0, sumHi[WIDTH:1]};
        multLo = {sumHi[0], accLo[WIDTH-1:1]};

        // Restoring divide step: shift the next dividend bit into the
        // remainder, then subtract the divisor on a trial basis. A
        // non-negative difference is kept, and a 1 goes into the quotient.
        shiftRem = {accHi[WIDTH-1:0], accLo[WIDTH-1]};
        trial    = {1'b0, shiftRem} - {2'b00, opMag};
        if (!trial[WIDTH+1]) begin
            divHi = trial[WIDTH:0];
            divLo = {accLo[WIDTH-2:0], 1'b1};
        end else begin
            divHi = shiftRem;
            divLo = {accLo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        productMag    = {multHi[WIDTH-1:0], multLo};
        productSigned = negResult ? (~productMag + 1'b1) : productMag;
        quotient      = negResult ? (~divLo + 1'b1) : divLo;
        // The product fits in WIDTH-bit signed only if the upper bits are a
        // pure sign extension of bit WIDTH-1.
        multOverflow  = !((&productSigned[2*WIDTH-1:WIDTH-1]) ||
                          (~|productSigned[2*WIDTH-1:WIDTH-1]));
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // FSM next state. A start pulse overrides every other transition.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: stateNext = IDLE;
            MULT: if (lastIter) stateNext = DONE;
            DIV:  if (lastIter) stateNext = DONE;
            DONE: stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (start) stateNext = ctrl_MULT ? MULT : DIV;
    end

    assign busy           = (state == MULT) || (state == DIV);
    assign data_resultRDY = (state == DONE);

    // Datapath and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            counter        <= '0;
            accHi          <= '0;
            accLo          <= '0;
            opMag          <= '0;
            negResult      <= 1'b0;
            divByZero      <= 1'b0;
            divOverflow    <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            counter     <= '0;
            accHi       <= '0;
            negResult   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            divByZero   <= (data_operandB == '0);
            divOverflow <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                           (data_operandB == '1);
            if (ctrl_MULT) begin
                accLo <= magB;
                opMag <= magA;
            end else begin
                accLo <= magA;
                opMag <= magB;
            end
        end else if (state == MULT) begin
            counter <= counter + 6'd1;
            accHi   <= multHi;
            accLo   <= multLo;
            if (lastIter) begin
                data_result    <= productSigned[WIDTH-1:0];
                data_exception <= multOverflow;
            end
        end else if (state == DIV) begin
            counter <= counter + 6'd1;
            accHi   <= divHi;
            accLo   <= divLo;
            if (lastIter) begin
                if (divByZero) begin
                    data_result    <= '0;
                    data_exception <= 1'b1;
                end else begin
                    // Most-negative / -1 wraps back to most-negative, which
                    // the negated quotient magnitude already produces.
                    data_result    <= quotient;
                    data_exception <= divOverflow;
                end
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// ---------------------------------------------------------------------------
// tb_multdiv_unit
//   Self-checking bench for multdiv_unit. It uses a table of directed
//   vectors, a randomized stream checked against an arithmetic reference
//   model, and hand-written sequences for restart, priority and
//   asynchronous reset.
// ---------------------------------------------------------------------------
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int nCompared   = 0;
    int nMismatched = 0;

    // Expected {exception, result} for each accepted operation.
    logic [32:0] exp_q[$];

    typedef struct {
        string       name;
        bit          mult;
        bit          div;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        bit          expExc;
    } vec_t;

    vec_t vecs[$];

    multdiv_unit #(.WIDTH(32)) dut (
        .clock         (clock),
        .reset         (reset),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy          (busy)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model built from signed arithmetic on wide integers.
    function automatic logic [32:0] model(input bit isMult, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        logic [63:0] rb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (isMult) begin
            r  = sa * sb;
            rb = r;
            return {(r > 64'sd2147483647) || (r < -64'sd2147483648), rb[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        r  = sa / sb;  // SystemVerilog division truncates toward zero
        rb = r;
        return {(r > 64'sd2147483647), rb[31:0]};
    endfunction

    // ---------------- driver ----------------
    // Pulse a start for one edge (E0). The operands are scrambled right after
    // E0 to confirm that they are captured at the start edge.
    task automatic pulseStart(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Wait for the strobe after a pulseStart. Check the latency, busy during
    // the wait, the result, and that the strobe lasts exactly one cycle.
    task automatic awaitResult(input string name);
        int          cyc;
        bit          busyOk;
        bit          seen;
        logic [32:0] e;
        logic [31:0] heldRes;
        busyOk = 1'b1;
        seen   = 1'b0;
        cyc    = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            cyc = i;
            if (data_resultRDY) begin
                seen = 1'b1;
                break;
            end
            if (!busy) busyOk = 1'b0;
        end
        if (!seen) begin
            check({name, "_timeout"}, 64'(cyc), 64'd33);
            return;
        end
        e = exp_q.pop_front();
        check({name, "_latency"},   64'(cyc),            64'd33);
        check({name, "_busy_iter"}, 64'(busyOk),         64'd1);
        check({name, "_busy_done"}, 64'(busy),           64'd0);
        check({name, "_result"},    64'(data_result),    64'(e[31:0]));
        check({name, "_exception"}, 64'(data_exception), 64'(e[32]));
        heldRes = data_result;
        @(negedge clock);
        check({name, "_rdy_one_cycle"}, 64'(data_resultRDY), 64'd0);
        check({name, "_result_hold"},   64'(data_result),    64'(heldRes));
    endtask

    task automatic runOp(input string name, input bit m, input bit d,
                         input logic [31:0] a, input logic [31:0] b);
        exp_q.push_back(model(m, a, b));  // multiply wins when both are high
        pulseStart(m, d, a, b);
        awaitResult(name);
    endtask

    // Count strobes over a window of cycles; used to prove that nothing fires.
    task automatic countStrobes(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (data_resultRDY) n++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          n;
        logic [31:0] ra, rb;
        bit          rm;
        logic [32:0] mv;

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        // Reset state. A start is driven during reset; it must be ignored.
        repeat (2) @(negedge clock);
        check("reset_result", 64'(data_result),    64'd0);
        check("reset_exc",    64'(data_exception), 64'd0);
        check("reset_rdy",    64'(data_resultRDY), 64'd0);
        check("reset_busy",   64'(busy),           64'd0);
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd3;
        data_operandB = 32'd3;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        reset     = 1'b1;
        countStrobes(40, n);
        check("start_in_reset_strobes", 64'(n), 64'd0);
        check("start_in_reset_result",  64'(data_result), 64'd0);

        // Directed vector table with hand-computed expectations.
        vecs.push_back('{"mul_small",     1, 0, 32'd7,          32'hFFFFFFFA, 32'hFFFFFFD6, 0});
        vecs.push_back('{"mul_ovf",       1, 0, 32'h00010000,   32'h00010000, 32'h00000000, 1});
        vecs.push_back('{"mul_min_x1",    1, 0, 32'h80000000,   32'd1,        32'h80000000, 0});
        vecs.push_back('{"mul_min_xneg1", 1, 0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"mul_zero",      1, 0, 32'h0,          32'h12345678, 32'h00000000, 0});
        vecs.push_back('{"div_neg7_2",    0, 1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 0});
        vecs.push_back('{"div_100_neg7",  0, 1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 0});
        vecs.push_back('{"div_by_zero",   0, 1, 32'd5,          32'd0,        32'h00000000, 1});
        vecs.push_back('{"div_min_neg1",  0, 1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"div_small_big", 0, 1, 32'd3,          32'd7,        32'h00000000, 0});
        vecs.push_back('{"both_6_3",      1, 1, 32'd6,          32'd3,        32'd18,       0});

        foreach (vecs[i]) begin
            // The table is also checked against the model, so a wrong
            // hand-written entry shows up as a comparison.
            mv = model(vecs[i].mult, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_model"}, 64'(mv), 64'({vecs[i].expExc, vecs[i].expRes}));
            exp_q.push_back({vecs[i].expExc, vecs[i].expRes});
            pulseStart(vecs[i].mult, vecs[i].div, vecs[i].a, vecs[i].b);
            awaitResult(vecs[i].name);
        end

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rm = $urandom_range(0, 1);
            case ($urandom_range(0, 4))
                0: ra = $urandom_range(0, 20);
                1: ra = 32'h80000000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'hFFFFFFFF;
                2: rb = $urandom_range(1, 300);
                default: rb = $urandom;
            endcase
            runOp($sformatf("rand%0d", i), rm, !rm, ra, rb);
        end

        // Restart: a divide aborts the multiply ten cycles in. Only the
        // divide strobes, 33 cycles after its own pulse.
        pulseStart(1, 0, 32'd3, 32'd4);
        repeat (9) @(negedge clock);
        exp_q.push_back({1'b0, 32'd4});
        pulseStart(0, 1, 32'd20, 32'd5);
        awaitResult("restart_div");
        countStrobes(40, n);
        check("restart_extra_strobes", 64'(n), 64'd0);

        // Asynchronous reset in the middle of a multiply (cycle 15).
        pulseStart(1, 0, 32'd5, 32'd5);
        repeat (14) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_result", 64'(data_result),    64'd0);
        check("async_rst_exc",    64'(data_exception), 64'd0);
        check("async_rst_rdy",    64'(data_resultRDY), 64'd0);
        check("async_rst_busy",   64'(busy),           64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        countStrobes(40, n);
        check("async_rst_no_strobe", 64'(n), 64'd0);
        check("async_rst_idle_busy", 64'(busy), 64'd0);
        runOp("post_reset_9x9", 1, 0, 32'd9, 32'd9);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Global watchdog; the run needs far fewer cycles than this.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        nMismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
